// File: rtl/cpu_divider_ctrl.sv
// Sequencer and datapath for the shared iterative divide unit: restoring radix-2 loop,
// sign fix-up, and a valid/ready result handshake toward the latent writeback port.
module cpu_divider_ctrl #(
   parameter int WIDTH     = 32,
   parameter bit FAST_ZERO = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             p4_start,
   input  logic [1:0]       p4_op,
   input  logic [WIDTH-1:0] p4_a,
   input  logic [WIDTH-1:0] p4_b,
   input  logic [4:0]       p4_dest,
   output logic             p4_divider_busy,
   output logic             div_valid,
   input  logic             div_ready,
   output logic [WIDTH-1:0] div_result,
   output logic [4:0]       div_dest
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [4:0]       dest_q, dest_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             sel_rem_q, sel_rem_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             zero_q, zero_d;

   logic             a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] q_fix, r_fix;

   assign a_neg  = ~p4_op[0] & p4_a[WIDTH-1];
   assign b_neg  = ~p4_op[0] & p4_b[WIDTH-1];
   assign b_zero = (p4_b == '0);
   assign a_mag  = a_neg ? -p4_a : p4_a;
   assign b_mag  = b_neg ? -p4_b : p4_b;

   // Remainder can reach 2*divisor-1 after the shift, so the trial needs two extra bits.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = {1'b0, shifted} - {2'b00, dvsr_q};

   // A zero divisor yields an all-ones quotient; the remainder path already restores a.
   assign q_fix = zero_q ? '1 : (qneg_q ? -quo_q : quo_q);
   assign r_fix = rneg_q ? -rem_q : rem_q;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case can infer a latch.
      state_d   = state_q;
      valid_d   = valid_q;
      result_d  = result_q;
      dest_d    = dest_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      sel_rem_d = sel_rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      zero_d    = zero_q;

      case (state_q)
         S_IDLE: begin
            if (p4_start) begin
               sel_rem_d = p4_op[1];
               dest_d    = p4_dest;
               quo_d     = a_mag;
               dvsr_d    = b_mag;
               rem_d     = '0;
               cnt_d     = CW'(WIDTH - 1);
               qneg_d    = a_neg ^ b_neg;
               rneg_d    = a_neg;
               zero_d    = b_zero;
               if (FAST_ZERO && b_zero) begin
                  result_d = p4_op[1] ? p4_a : '1;
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (!trial[WIDTH+1]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            result_d = sel_rem_q ? r_fix : q_fix;
            valid_d  = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (div_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         result_q  <= '0;
         dest_q    <= '0;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         sel_rem_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         result_q  <= result_d;
         dest_q    <= dest_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         sel_rem_q <= sel_rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         zero_q    <= zero_d;
      end
   end

   assign p4_divider_busy = busy_q;
   assign div_valid       = valid_q;
   assign div_result      = result_q;
   assign div_dest        = dest_q;

endmodule

// File: tb/tb_cpu_divider_ctrl.sv
// Directed and randomised checks of cpu_divider_ctrl: latency, sign rules, divide by zero,
// overflow, writeback backpressure, asynchronous reset and a reference-model sweep.
module tb_cpu_divider_ctrl;

   localparam logic [1:0] DIVS = 2'b00, DIVU = 2'b01, MODS = 2'b10, MODU = 2'b11;
   localparam int LAT_FULL = 34;
   localparam int LAT_ZERO = 1;

   logic        clock = 1'b0;
   logic        reset;
   logic        p4_start;
   logic [1:0]  p4_op;
   logic [31:0] p4_a, p4_b;
   logic [4:0]  p4_dest;
   logic        p4_divider_busy;
   logic        div_valid;
   logic        div_ready;
   logic [31:0] div_result;
   logic [4:0]  div_dest;

   int checks = 0;
   int errors = 0;
   int viol   = 0;

   cpu_divider_ctrl #(.WIDTH(32), .FAST_ZERO(1'b1)) dut (
      .clock           (clock),
      .reset           (reset),
      .p4_start        (p4_start),
      .p4_op           (p4_op),
      .p4_a            (p4_a),
      .p4_b            (p4_b),
      .p4_dest         (p4_dest),
      .p4_divider_busy (p4_divider_busy),
      .div_valid       (div_valid),
      .div_ready       (div_ready),
      .div_result      (div_result),
      .div_dest        (div_dest)
   );

   always #5 clock = ~clock;

   // Decoder protocol monitor: a start presented while the unit is busy.
   always @(posedge clock) if (!reset && p4_start && p4_divider_busy) viol++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (op[0]) return op[1] ? (a % b) : (a / b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
   endfunction

   // Issue at cycle T, wait for div_valid, check latency/result/dest, optionally accept.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dest,
                         input logic [31:0] exp_res, input int exp_lat, input bit accept);
      int lat;
      p4_start = 1'b1;
      p4_op    = op;
      p4_a     = a;
      p4_b     = b;
      p4_dest  = dest;
      tick();
      p4_start = 1'b0;
      p4_a     = 32'hDEAD_BEEF;
      p4_b     = 32'h0000_0003;
      check({tag, " busy"}, 64'(p4_divider_busy), 64'd1);
      lat = 1;
      while (div_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, 64'(div_result), 64'(exp_res));
      check({tag, " dest"}, 64'(div_dest), 64'(dest));
      if (accept) begin
         tick();
         check({tag, " busy after accept"}, 64'(p4_divider_busy), 64'd0);
         check({tag, " valid after accept"}, 64'(div_valid), 64'd0);
      end
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      reset     = 1'b1;
      p4_start  = 1'b0;
      p4_op     = 2'b00;
      p4_a      = '0;
      p4_b      = '0;
      p4_dest   = '0;
      div_ready = 1'b1;
      #2;
      check("reset busy", 64'(p4_divider_busy), 64'd0);
      check("reset valid", 64'(div_valid), 64'd0);
      check("reset result", 64'(div_result), 64'd0);
      check("reset dest", 64'(div_dest), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      run_op("divu 100/7", DIVU, 32'd100, 32'd7, 5'd12, 32'd14, LAT_FULL, 1'b1);
      run_op("mods -7,2", MODS, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, LAT_FULL, 1'b1);
      run_op("divs -7/2", DIVS, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, LAT_FULL, 1'b1);
      run_op("divs 7/-2", DIVS, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, LAT_FULL, 1'b1);
      run_op("modu 1000,7", MODU, 32'd1000, 32'd7, 5'd31, 32'd6, LAT_FULL, 1'b1);
      run_op("divu big", DIVU, 32'hFFFF_FFFF, 32'd16, 5'd4, 32'h0FFF_FFFF, LAT_FULL, 1'b1);
      run_op("divu 5/0", DIVU, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF, LAT_ZERO, 1'b1);
      run_op("mods -5,0", MODS, 32'hFFFF_FFFB, 32'd0, 5'd6, 32'hFFFF_FFFB, LAT_ZERO, 1'b1);
      run_op("divs -5/0", DIVS, 32'hFFFF_FFFB, 32'd0, 5'd7, 32'hFFFF_FFFF, LAT_ZERO, 1'b1);
      run_op("divs ovf", DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, LAT_FULL, 1'b1);
      run_op("mods ovf", MODS, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, LAT_FULL, 1'b1);
      run_op("divu dest0", DIVU, 32'd81, 32'd9, 5'd0, 32'd9, LAT_FULL, 1'b1);

      // Writeback backpressure with ignored starts while busy.
      div_ready = 1'b0;
      run_op("bp divu", DIVU, 32'd1000, 32'd7, 5'd9, 32'd142, LAT_FULL, 1'b0);
      for (int i = 0; i < 10; i++) begin
         p4_start = (i % 2 == 0);
         p4_op    = MODU;
         p4_a     = 32'd55 + 32'(i);
         p4_b     = 32'd0;
         p4_dest  = 5'd20;
         tick();
         check("bp result held", 64'(div_result), 64'd142);
         check("bp dest held", 64'(div_dest), 64'd9);
         check("bp busy held", 64'(p4_divider_busy), 64'd1);
         check("bp valid held", 64'(div_valid), 64'd1);
      end
      p4_start  = 1'b0;
      check("protocol violations seen", 64'(viol), 64'd5);
      div_ready = 1'b1;
      tick();
      check("bp busy drops", 64'(p4_divider_busy), 64'd0);
      check("bp valid drops", 64'(div_valid), 64'd0);
      run_op("bp back-to-back", MODU, 32'd1000, 32'd7, 5'd3, 32'd6, LAT_FULL, 1'b1);

      // Asynchronous reset in the middle of RUN.
      p4_start = 1'b1;
      p4_op    = DIVU;
      p4_a     = 32'd999;
      p4_b     = 32'd3;
      p4_dest  = 5'd17;
      tick();
      p4_start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("pre-reset busy", 64'(p4_divider_busy), 64'd1);
      reset = 1'b1;
      #1;
      check("async reset busy", 64'(p4_divider_busy), 64'd0);
      check("async reset valid", 64'(div_valid), 64'd0);
      check("async reset result", 64'(div_result), 64'd0);
      check("async reset dest", 64'(div_dest), 64'd0);
      tick();
      reset = 1'b0;
      tick();
      check("post-reset busy", 64'(p4_divider_busy), 64'd0);
      run_op("post-reset divs", DIVS, 32'hFFFF_FF9C, 32'd7, 5'd11, 32'hFFFF_FFF2, LAT_FULL, 1'b1);

      // Randomised sweep against the reference model.
      for (int n = 0; n < 200; n++) begin
         rop = 2'($urandom_range(3));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(3) == 0) rb = 32'($urandom_range(15));
         if ($urandom_range(7) == 0) rb = 32'hFFFF_FFFF;
         if ($urandom_range(15) == 0) ra = 32'h8000_0000;
         run_op("sweep", rop, ra, rb, 5'($urandom_range(31)), ref_div(rop, ra, rb),
                (rb == 32'd0) ? LAT_ZERO : LAT_FULL, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
